// File: rtl/frame_bank_pkg.sv
// Shared constants, startup sequencing states and helpers for the frame bank arbiter.
package frame_bank_pkg;

  localparam int unsigned RD_BANK_RST = 0;
  localparam int unsigned WR_BANK_RST = 1;
  localparam int unsigned MIN_BANKS   = 2;
  localparam int unsigned MAX_BANKS   = 8;

  typedef enum logic [1:0] {
    ST_INIT0,
    ST_INIT1,
    ST_RUN
  } start_state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fba_edge_sync.sv
// Two-flop synchroniser with registered rising-edge pulse for an asynchronous done level.
module fba_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      pulse <= s1 & ~s2;
    end
  end

endmodule

// File: rtl/frame_bank_arbiter.sv
// N-bank frame buffer arbiter between camera write path and VGA read path.
// Optional statistics counters enabled by defining FRAME_STATS_EN.
module frame_bank_arbiter
  import frame_bank_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 3,
  parameter int unsigned BANK_W    = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_write_done,
  input  logic              frame_read_done,
  output logic [BANK_W-1:0] write_bank_address,
  output logic [BANK_W-1:0] read_bank_address,
  output logic              write_address_set,
  output logic              read_address_set,
  output logic              frame_read_done_buff,
  output logic              ready_valid
`ifdef FRAME_STATS_EN
  ,
  output logic [CNT_W-1:0]  frame_drop_cnt,
  output logic [CNT_W-1:0]  frame_repeat_cnt
`endif
);

  localparam int unsigned MIN_W = (clog2(NUM_BANKS) < 1) ? 1 : clog2(NUM_BANKS);

  if (NUM_BANKS < MIN_BANKS || NUM_BANKS > MAX_BANKS) begin : g_bad_banks
    $error("frame_bank_arbiter: NUM_BANKS out of range");
  end
  if (BANK_W < MIN_W) begin : g_bad_bank_w
    $error("frame_bank_arbiter: BANK_W too small for NUM_BANKS");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("frame_bank_arbiter: CNT_W must be at least 1");
  end

  logic              wr_ev;
  logic              rd_ev;
  logic [BANK_W-1:0] ready_bank;
  start_state_t      state;

  logic [BANK_W-1:0] nxt_write;
  logic [BANK_W-1:0] nxt_read;
  logic [BANK_W-1:0] nxt_ready;
  logic              nxt_valid;
  logic              wset;
  logic              rset;

  fba_edge_sync u_wr_sync (
    .clk   (clk),
    .reset (reset),
    .din   (frame_write_done),
    .pulse (wr_ev)
  );

  fba_edge_sync u_rd_sync (
    .clk   (clk),
    .reset (reset),
    .din   (frame_read_done),
    .pulse (frame_read_done_buff)
  );

  assign rd_ev = frame_read_done_buff;

  // Lowest bank index that is neither a nor b.
  function automatic logic [BANK_W-1:0] free_bank(input logic [BANK_W-1:0] a,
                                                 input logic [BANK_W-1:0] b);
    logic [BANK_W-1:0] pick;
    pick = '0;
    for (int unsigned i = NUM_BANKS; i > 0; i--) begin
      if (BANK_W'(i - 1) != a && BANK_W'(i - 1) != b) pick = BANK_W'(i - 1);
    end
    return pick;
  endfunction

  always_comb begin
    nxt_write = write_bank_address;
    nxt_read  = read_bank_address;
    nxt_ready = ready_bank;
    nxt_valid = ready_valid;
    wset      = 1'b0;
    rset      = 1'b0;
    if (NUM_BANKS == 2) begin
      // Read switch compares against the write bank before any toggle this cycle.
      if (rd_ev && write_bank_address == read_bank_address) begin
        nxt_read = (read_bank_address == '0) ? BANK_W'(1) : '0;
        rset     = 1'b1;
      end
      if (wr_ev) begin
        nxt_write = (write_bank_address == '0) ? BANK_W'(1) : '0;
        wset      = 1'b1;
      end
      nxt_valid = (nxt_write == nxt_read);
    end else begin
      if (wr_ev && rd_ev) begin
        nxt_ready = write_bank_address;
        nxt_read  = write_bank_address;
        nxt_valid = 1'b0;
        nxt_write = free_bank(write_bank_address, write_bank_address);
        wset      = 1'b1;
        rset      = 1'b1;
      end else if (wr_ev) begin
        nxt_ready = write_bank_address;
        nxt_valid = 1'b1;
        nxt_write = free_bank(read_bank_address, write_bank_address);
        wset      = 1'b1;
      end else if (rd_ev && ready_valid) begin
        nxt_read  = ready_bank;
        nxt_valid = 1'b0;
        rset      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= ST_INIT0;
      write_bank_address <= BANK_W'(WR_BANK_RST);
      read_bank_address  <= BANK_W'(RD_BANK_RST);
      ready_bank         <= BANK_W'(RD_BANK_RST);
      ready_valid        <= 1'b0;
      write_address_set  <= 1'b0;
      read_address_set   <= 1'b0;
`ifdef FRAME_STATS_EN
      frame_drop_cnt     <= '0;
      frame_repeat_cnt   <= '0;
`endif
    end else begin
      write_bank_address <= nxt_write;
      read_bank_address  <= nxt_read;
      ready_bank         <= nxt_ready;
      ready_valid        <= nxt_valid;
      write_address_set  <= wset | (state == ST_INIT1);
      read_address_set   <= rset | (state == ST_INIT1);
      case (state)
        ST_INIT0: state <= ST_INIT1;
        ST_INIT1: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
`ifdef FRAME_STATS_EN
      if (NUM_BANKS > 2 && wr_ev && !rd_ev && ready_valid && frame_drop_cnt != '1)
        frame_drop_cnt <= frame_drop_cnt + CNT_W'(1);
      if (rd_ev && !rset && frame_repeat_cnt != '1)
        frame_repeat_cnt <= frame_repeat_cnt + CNT_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_frame_bank_arbiter.sv
// Bench for frame_bank_arbiter: three instances (N=3, N=4, N=2) against a rule-level model.
module tb_frame_bank_arbiter;

  logic       clk;
  logic       reset;
  logic       wd   [3];
  logic       rdn  [3];
  logic [2:0] wa   [3];
  logic [2:0] ra   [3];
  logic       ws   [3];
  logic       rs   [3];
  logic       buff [3];
  logic       rv   [3];
`ifdef FRAME_STATS_EN
  logic [2:0] dc   [3];
  logic [2:0] rc   [3];
`endif

  int checks   = 0;
  int failures = 0;

  int nb [3] = '{3, 4, 2};
  int m_w [3], m_r [3], m_rdy [3], m_rv [3], m_drop [3], m_rep [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  frame_bank_arbiter #(.NUM_BANKS(3), .BANK_W(3), .CNT_W(3)) u_n3 (
    .clk(clk), .reset(reset), .frame_write_done(wd[0]), .frame_read_done(rdn[0]),
    .write_bank_address(wa[0]), .read_bank_address(ra[0]),
    .write_address_set(ws[0]), .read_address_set(rs[0]),
    .frame_read_done_buff(buff[0]), .ready_valid(rv[0])
`ifdef FRAME_STATS_EN
    , .frame_drop_cnt(dc[0]), .frame_repeat_cnt(rc[0])
`endif
  );

  frame_bank_arbiter #(.NUM_BANKS(4), .BANK_W(3), .CNT_W(3)) u_n4 (
    .clk(clk), .reset(reset), .frame_write_done(wd[1]), .frame_read_done(rdn[1]),
    .write_bank_address(wa[1]), .read_bank_address(ra[1]),
    .write_address_set(ws[1]), .read_address_set(rs[1]),
    .frame_read_done_buff(buff[1]), .ready_valid(rv[1])
`ifdef FRAME_STATS_EN
    , .frame_drop_cnt(dc[1]), .frame_repeat_cnt(rc[1])
`endif
  );

  frame_bank_arbiter #(.NUM_BANKS(2), .BANK_W(3), .CNT_W(3)) u_n2 (
    .clk(clk), .reset(reset), .frame_write_done(wd[2]), .frame_read_done(rdn[2]),
    .write_bank_address(wa[2]), .read_bank_address(ra[2]),
    .write_address_set(ws[2]), .read_address_set(rs[2]),
    .frame_read_done_buff(buff[2]), .ready_valid(rv[2])
`ifdef FRAME_STATS_EN
    , .frame_drop_cnt(dc[2]), .frame_repeat_cnt(rc[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x >= 7) ? 7 : x + 1;
  endfunction

  // Lowest bank not occupied by either of the two given banks.
  function automatic int lowest_free(input int n, input int a, input int b);
    bit [7:0] used;
    used = '0;
    used[a] = 1'b1;
    used[b] = 1'b1;
    for (int i = 0; i < n; i++) if (!used[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_w[k] = 1; m_r[k] = 0; m_rdy[k] = 0; m_rv[k] = 0; m_drop[k] = 0; m_rep[k] = 0;
    end
  endtask

  // Apply one decision cycle with write/read events; returns expected set pulses.
  task automatic model_event(input int k, input bit w, input bit r,
                             output bit ew, output bit er);
    ew = w;
    if (nb[k] == 2) begin
      er = r && (m_w[k] == m_r[k]);
      if (er) m_r[k] = 1 - m_r[k];
      else if (r) m_rep[k] = sat(m_rep[k]);
      if (w) m_w[k] = 1 - m_w[k];
      m_rv[k] = (m_w[k] == m_r[k]) ? 1 : 0;
    end else begin
      er = r && (w || m_rv[k] != 0);
      if (w) begin
        if (m_rv[k] != 0 && !r) m_drop[k] = sat(m_drop[k]);
        m_rdy[k] = m_w[k];
        m_rv[k]  = 1;
      end
      if (r) begin
        if (m_rv[k] != 0) begin
          m_r[k]  = m_rdy[k];
          m_rv[k] = 0;
        end else m_rep[k] = sat(m_rep[k]);
      end
      if (w) m_w[k] = lowest_free(nb[k], m_r[k], m_rdy[k]);
    end
  endtask

  task automatic check_state(input int k, input bit ew, input bit er, input string ph);
    string p;
    p = $sformatf("n%0d_%s", nb[k], ph);
    chk({p, "_wbank"}, 32'(wa[k]), 32'(m_w[k]));
    chk({p, "_rbank"}, 32'(ra[k]), 32'(m_r[k]));
    chk({p, "_valid"}, 32'(rv[k]), 32'(m_rv[k]));
    chk({p, "_wset"},  32'(ws[k]), 32'(ew));
    chk({p, "_rset"},  32'(rs[k]), 32'(er));
`ifdef FRAME_STATS_EN
    chk({p, "_drop"},  32'(dc[k]), 32'(m_drop[k]));
    chk({p, "_rep"},   32'(rc[k]), 32'(m_rep[k]));
`endif
  endtask

  task automatic do_event(input int k, input bit w, input bit r);
    bit ew, er;
    @(negedge clk);
    wd[k]  = w;
    rdn[k] = r;
    @(posedge clk);
    @(posedge clk); #1;
    chk($sformatf("n%0d_buff_pulse", nb[k]), 32'(buff[k]), 32'(r));
    @(posedge clk); #1;
    model_event(k, w, r, ew, er);
    check_state(k, ew, er, "ev");
    chk($sformatf("n%0d_buff_clear", nb[k]), 32'(buff[k]), 32'd0);
    @(posedge clk); #1;
    check_state(k, 1'b0, 1'b0, "post");
    @(negedge clk);
    wd[k]  = 1'b0;
    rdn[k] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic startup_check(input string ph);
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) check_state(k, e == 2, e == 2, $sformatf("%s_e%0d", ph, e));
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wd[k]  = 1'b0;
      rdn[k] = 1'b0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_state(k, 1'b0, 1'b0, "rst");
      chk($sformatf("n%0d_rst_buff", nb[k]), 32'(buff[k]), 32'd0);
    end
    startup_check("start");

    // Write then read, then drop, on N=3.
    do_event(0, 1'b1, 1'b0);
    do_event(0, 1'b0, 1'b1);
    do_event(0, 1'b1, 1'b0);
    do_event(0, 1'b1, 1'b0);
    // Simultaneous events on N=4.
    do_event(1, 1'b1, 1'b1);
    // Legacy ping-pong on N=2.
    do_event(2, 1'b0, 1'b1);
    do_event(2, 1'b1, 1'b0);
    do_event(2, 1'b0, 1'b1);

    // Reset while a write edge is still in flight.
    @(negedge clk);
    wd[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      check_state(k, 1'b0, 1'b0, "midrst");
      chk($sformatf("n%0d_midrst_buff", nb[k]), 32'(buff[k]), 32'd0);
    end
    @(negedge clk);
    wd[0] = 1'b0;
    repeat (3) @(posedge clk);
    startup_check("restart");

    repeat (60) begin
      int k;
      bit w, r;
      k = int'($urandom_range(0, 2));
      w = 1'($urandom);
      r = 1'($urandom);
      if (!w && !r) w = 1'b1;
      do_event(k, w, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_bank_arbiter.md
Name: frame_bank_arbiter

Overview:
- N-bank successor to the two-bank ping-pong switch between the camera write path and the VGA read path of the SDRAM frame buffer.
- Tracks which bank the writer fills, which the reader scans, and which completed bank is newest.
- With NUM_BANKS>=3 the writer never enters the bank being read (tear-free triple+ buffering).
- With NUM_BANKS=2 it keeps the legacy ping-pong rules.
- Sits between the SDRAM controller address muxes and the camera capture / VGA timing blocks.

Parameters:
NUM_BANKS, 3, number of frame banks (2..8)
BANK_W, 2, bank address width; must be >= max(1, clog2(NUM_BANKS)), checked at elaboration
CNT_W, 16, width of statistics counters (only used with FRAME_STATS_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
frame_write_done  input  1  level from capture path; rising edge = frame written (may be asynchronous)
frame_read_done  input  1  level from VGA path; rising edge = frame scanned out (may be asynchronous)
write_bank_address  output  BANK_W  bank the writer fills
read_bank_address  output  BANK_W  bank the reader scans
write_address_set  output  1  one-cycle pulse: write bank (re)loaded
read_address_set  output  1  one-cycle pulse: read bank (re)loaded
frame_read_done_buff  output  1  synchronised one-cycle rising-edge pulse of frame_read_done
ready_valid  output  1  a completed, unread frame is held in ready_bank
frame_drop_cnt  output  CNT_W  completed frames overwritten unread (FRAME_STATS_EN only)
frame_repeat_cnt  output  CNT_W  read frames that re-scanned the same bank (FRAME_STATS_EN only)

Behaviour:
Reset values:
- read_bank_address=0, write_bank_address=1, internal ready_bank=0.
- ready_valid=0, both set pulses=0, frame_read_done_buff=0, counters=0.
- Synchroniser flops also reset.

Edge detection:
- Each done input goes through a 2-flop synchroniser plus rise detect.
- Done sampled high at edge E gives an internal pulse registered at E+1.
- Bank registers update at E+2; the corresponding address_set is high for exactly the cycle following E+2.

Startup:
- After reset release, write_address_set pulses on the 2nd clock and read_address_set on the 2nd clock.
- Both set pulses are then low until an arbitration event.

Arbitration in a decision cycle, NUM_BANKS>=3:
- Read event (rd_ev): if ready_valid, then next_read=ready_bank, ready_valid cleared, read_address_set pulsed. Otherwise read bank is unchanged, no pulse, repeat++.
- Write event (wr_ev): the current write bank becomes ready_bank and ready_valid=1. If ready_valid was already 1, the old ready frame is dropped (drop++).
- Next write bank on wr_ev = lowest index not equal to next_read and not equal to the new ready_bank; write_address_set is pulsed.
- Simultaneous rd_ev and wr_ev: apply wr_ev first, so the reader takes the just-completed bank.
  - ready_valid ends 0.
  - Writer picks the lowest index not equal to next_read.
  - No drop counted.
- A free bank always exists for N>=3.

NUM_BANKS=2 (legacy mode):
- wr_ev toggles the write bank unconditionally and pulses write_address_set.
- rd_ev switches the read bank to the other bank only if write_bank==read_bank at that cycle; otherwise read stays (repeat++).
- Simultaneous events evaluate the rd_ev compare against the pre-toggle write bank.
- ready_valid = (write_bank==read_bank).

Other rules:
- Bank indices never exceed NUM_BANKS-1.
- Counters saturate at all-ones.
- Reset asserted mid-frame returns everything to reset values immediately, including in-flight edge pulses.

Optional Feature:
FRAME_STATS_EN:
- Defined: frame_drop_cnt and frame_repeat_cnt ports exist and count as above, saturating.
- Undefined: the ports and counters are absent; arbitration is unchanged.

Decomposition:
Package frame_bank_pkg holds:
- reset constants RD_BANK_RST=0, WR_BANK_RST=1.
- clog2 helper function.
- legal NUM_BANKS range.

Sub-module fba_edge_sync:
- 2-flop synchroniser plus rising-edge pulse, async active-low reset.
- Instantiated twice; its read output drives frame_read_done_buff.

Free-bank selection is a combinational priority function inside the top module.

Test Plan:
- Startup, N=3: release reset → read=0, write=1, ready_valid=0; write_address_set and read_address_set each one pulse on the 2nd clock; no further pulses.
- Write then read, N=3: frame_write_done rise → ready_bank=1, ready_valid=1, write=2 (3 edges later), write_address_set pulse. Then frame_read_done rise → read=1, ready_valid=0, read_address_set pulse.
- Drop, N=3: two write-done edges with no read → second edge sets ready_bank=2 and write=1; frame_drop_cnt=1 with FRAME_STATS_EN.
- Simultaneous edges, N=4: read=0, write=1, ready_valid=0, both done rise on the same clock → read=1, write=0, ready_valid=0, both set pulses on the same cycle, drop=0.
- Legacy, N=2: read=0, write=1; read-done → read stays 0, repeat=1. Write-done → write=0. Read-done → read=1, read_address_set pulse.
- Reset mid-operation: assert reset one cycle after a frame_write_done rise → all outputs at reset values, no pulse after release other than the startup pulses.
